// File: rtl/tetris_row_clear_ctrl.sv
// rtl/tetris_row_clear_ctrl.sv - line-clear sequencer for the playfield row store
// Optional weighted scoring is enabled by defining LINE_SCORE_EN.
module tetris_row_clear_ctrl #(
  parameter int                ROWS      = 24,
  parameter int                COLS      = 32,
  parameter int                AW        = 5,
  parameter logic [COLS-1:0]   FULL_MASK = 32'h00FFFF00
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   row_addr,
  input  logic [COLS-1:0] row_rdata,
  output logic [COLS-1:0] row_wdata,
  output logic            row_we,
  output logic [AW-1:0]   lines,
  output logic [15:0]     score
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_EV,
    S_CLR,
    S_FIN
  } state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_rd, w_rd_nxt;
  logic [AW-1:0] r_wr, w_wr_nxt;
  logic [AW-1:0] r_n, w_n_nxt;
  logic [AW-1:0] r_lines;
  logic [15:0]   r_score;
  logic          w_full;
  logic [15:0]   w_inc;
  logic [16:0]   w_sum;
  logic [15:0]   w_score_nxt;

  assign w_full = (row_rdata & FULL_MASK) == FULL_MASK;
  assign lines  = r_lines;
  assign score  = r_score;

  always_comb begin
    w_inc = '0;
`ifdef LINE_SCORE_EN
    if (r_n >= AW'(4))      w_inc = 16'd8;
    else if (r_n == AW'(3)) w_inc = 16'd5;
    else if (r_n == AW'(2)) w_inc = 16'd3;
    else if (r_n == AW'(1)) w_inc = 16'd1;
    else                    w_inc = 16'd0;
`else
    w_inc = 16'(r_n);
`endif
  end

  // Saturate rather than wrap so long games never reset the score.
  assign w_sum       = {1'b0, r_score} + {1'b0, w_inc};
  assign w_score_nxt = w_sum[16] ? 16'hFFFF : w_sum[15:0];

  always_comb begin
    w_state_nxt = r_state;
    w_rd_nxt    = r_rd;
    w_wr_nxt    = r_wr;
    w_n_nxt     = r_n;
    busy        = 1'b1;
    done        = 1'b0;
    row_addr    = '0;
    row_wdata   = '0;
    row_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_rd_nxt    = LAST_ROW;
          w_wr_nxt    = LAST_ROW;
          w_n_nxt     = '0;
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        row_addr    = r_rd;
        w_state_nxt = S_WT;
      end
      S_WT: begin
        row_addr    = r_rd;
        w_state_nxt = S_EV;
      end
      S_EV: begin
        row_addr = r_rd;
        if (w_full) begin
          w_n_nxt = r_n + ONE;
        end else begin
          w_wr_nxt = r_wr - ONE;
          if (r_wr != r_rd) begin
            row_addr  = r_wr;
            row_wdata = row_rdata;
            row_we    = 1'b1;
          end
        end
        // The clear count used here already includes the row just evaluated.
        if (r_rd == '0) begin
          w_state_nxt = (w_n_nxt != '0) ? S_CLR : S_FIN;
        end else begin
          w_rd_nxt    = r_rd - ONE;
          w_state_nxt = S_RD;
        end
      end
      S_CLR: begin
        row_addr = r_wr;
        row_we   = 1'b1;
        if (r_wr == '0) w_state_nxt = S_FIN;
        else            w_wr_nxt    = r_wr - ONE;
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_rd    <= '0;
      r_wr    <= '0;
      r_n     <= '0;
      r_lines <= '0;
      r_score <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_n     <= w_n_nxt;
      if (r_state == S_FIN) begin
        r_lines <= r_n;
        r_score <= w_score_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tetris_row_clear_ctrl.sv
// tb/tb_tetris_row_clear_ctrl.sv - directed table-driven bench for tetris_row_clear_ctrl
module tb_tetris_row_clear_ctrl;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  row_addr;
  logic [31:0] row_rdata;
  logic [31:0] row_wdata;
  logic        row_we;
  logic [4:0]  lines;
  logic [15:0] score;

  tetris_row_clear_ctrl dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .row_addr  (row_addr),
    .row_rdata (row_rdata),
    .row_wdata (row_wdata),
    .row_we    (row_we),
    .lines     (lines),
    .score     (score)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem   [0:31];
  logic [31:0] board [0:31];
  logic        load;

  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 32; i++) mem[i] <= board[i];
    end else begin
      if (row_we) mem[row_addr] <= row_wdata;
    end
    row_rdata <= mem[row_addr];
  end

`ifdef LINE_SCORE_EN
  localparam int S3 = 9;
  localparam int S4 = 17;
  localparam int S5 = 18;
`else
  localparam int S3 = 5;
  localparam int S4 = 29;
  localparam int S5 = 30;
`endif

  typedef struct {
    int          pass;
    int          item;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [$];
  int          n_vec;
  int          n_bad;
  int          res_done  [0:7];
  int          res_lines [0:7];
  int          res_score [0:7];
  int          res_wr    [0:7];
  int          res_pulse [0:7];
  int          res_busy  [0:7];
  logic [31:0] snap      [0:7][0:31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int p, input int it, input logic [31:0] e);
    vec_t v;
    v.pass = p;
    v.item = it;
    v.exp  = e;
    vt.push_back(v);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 32; i++) board[i] = 32'h0;
  endtask

  task automatic run_pass(input int p, input bit inject);
    int cyc;
    int rd;
    bit got;
    @(negedge clock);
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cyc = 1;
    rd  = -1;
    got = 1'b0;
    res_wr[p]    = 0;
    res_pulse[p] = 0;
    res_busy[p]  = -1;
    while (cyc < 300) begin
      if (row_we) res_wr[p]++;
      if (done) begin
        res_pulse[p]++;
        if (!got) begin
          got = 1'b1;
          rd  = cyc;
        end
      end
      if (got && cyc == rd + 1) res_busy[p] = int'(busy);
      start = inject && (cyc == 10 || done);
      if (got && cyc >= rd + 4) break;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    if (!got) chk($sformatf("pass%0d_timeout", p), 32'd0, 32'd1);
    res_done[p]  = rd;
    res_lines[p] = int'(lines);
    res_score[p] = int'(score);
    @(negedge clock);
    for (int i = 0; i < 32; i++) snap[p][i] = mem[i];
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    start  = 1'b0;
    load   = 1'b0;
    resetn = 1'b0;
    clear_board();

    // items: 0 done cycle, 1 lines, 2 score, 3 write cycles, 4 done pulses, 5 busy after FIN, 100+r row r
    add(1, 0, 73); add(1, 1, 0); add(1, 2, 0); add(1, 3, 0); add(1, 4, 1);
    add(2, 0, 74); add(2, 1, 1); add(2, 2, 1); add(2, 3, 24);
    add(2, 123, 32'h00010000); add(2, 122, 32'h0); add(2, 100, 32'h0);
    add(3, 0, 77); add(3, 1, 4); add(3, 2, S3); add(3, 3, 24);
    add(3, 123, 32'h00F00000); add(3, 119, 32'h00FFFE00); add(3, 114, 32'hFF0000FF);
    add(3, 115, 32'h0); add(3, 110, 32'h0); add(3, 122, 32'h0); add(3, 103, 32'h0);
    add(4, 0, 97); add(4, 1, 24); add(4, 2, S4); add(4, 3, 24);
    add(4, 100, 32'h0); add(4, 112, 32'h0); add(4, 123, 32'h0);
    add(5, 0, 74); add(5, 1, 1); add(5, 2, S5); add(5, 4, 1); add(5, 5, 0);
    add(7, 0, 74); add(7, 1, 1); add(7, 2, 1); add(7, 123, 32'h0); add(7, 122, 32'h1);

    @(negedge clock);
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk($sformatf("idle_c%0d", c), {5'd0, row_addr, busy, done, row_we, lines, score},
          32'h0);
    end

    clear_board();
    run_pass(1, 1'b0);

    board[23] = 32'h00FFFF00;
    board[22] = 32'h00010000;
    run_pass(2, 1'b0);

    clear_board();
    for (int i = 20; i < 24; i++) board[i] = 32'hFFFFFFFF;
    board[19] = 32'h00F00000;
    board[15] = 32'h00FFFE00;
    board[10] = 32'hFF0000FF;
    run_pass(3, 1'b0);

    for (int i = 0; i < 24; i++) board[i] = 32'hFFFFFFFF;
    run_pass(4, 1'b0);

    clear_board();
    board[23] = 32'h00FFFF00;
    run_pass(5, 1'b1);

    board[23] = 32'hFFFFFFFF;
    board[21] = 32'h00000001;
    @(negedge clock);
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 1; c < 30; c++) @(negedge clock);
    chk("midpass_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_we", {31'd0, row_we}, 32'd0);
    chk("rst_score", {16'd0, score}, 32'd0);
    chk("rst_lines_done", {26'd0, lines, done}, 32'd0);
    resetn = 1'b1;
    run_pass(7, 1'b0);

    foreach (vt[k]) begin
      logic [31:0] act;
      case (vt[k].item)
        0:       act = 32'(res_done[vt[k].pass]);
        1:       act = 32'(res_lines[vt[k].pass]);
        2:       act = 32'(res_score[vt[k].pass]);
        3:       act = 32'(res_wr[vt[k].pass]);
        4:       act = 32'(res_pulse[vt[k].pass]);
        5:       act = 32'(res_busy[vt[k].pass]);
        default: act = snap[vt[k].pass][vt[k].item - 100];
      endcase
      chk($sformatf("pass%0d_item%0d", vt[k].pass, vt[k].item), act, vt[k].exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
